// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: finds the ARM rotated-immediate encoding {rot, imm8} of a
// 32-bit constant (value = ROR(imm8, 2*rot)), or of its complement (MVN form).
// Latency r+2 cycles for a match at rotation r; 17 cycles when there is no
// encoding. While busy, start is ignored and is not queued.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, value      request and the constant; sampled only while busy=0
//   busy, done        busy in SEARCH/DONE; done is a one-cycle result strobe
//   found, inverted   encoding exists / encoding is of ~value
//   rot, imm8         rotate and immediate fields (0 when found=0)
//   encoded           {rot, imm8}, the 12-bit operand field
module imm_rot_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] value,
   output logic        busy,
   output logic        done,
   output logic        found,
   output logic        inverted,
   output logic [3:0]  rot,
   output logic [7:0]  imm8,
   output logic [11:0] encoded
);

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic [31:0] r_val;
   logic        r_found;
   logic        r_inv;
   logic [3:0]  r_rot;
   logic [7:0]  r_imm8;

   logic [4:0]  w_sh;
   logic [31:0] w_nval;
   logic [31:0] w_p;
   logic [31:0] w_n;
   logic        w_p_hit;
   logic        w_n_hit;
   logic        w_last;

   // Rotate left by 2*cnt. A right shift by 32 (when w_sh is 0) yields zero,
   // so the OR collapses to the unrotated value without a special case.
   assign w_sh    = {r_cnt, 1'b0};
   assign w_nval  = ~r_val;
   assign w_p     = (r_val  << w_sh) | (r_val  >> (6'd32 - {1'b0, w_sh}));
   assign w_n     = (w_nval << w_sh) | (w_nval >> (6'd32 - {1'b0, w_sh}));
   assign w_p_hit = (w_p[31:8] == 24'd0);
   assign w_n_hit = (w_n[31:8] == 24'd0);
   assign w_last  = (r_cnt == 4'd15);

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_SEARCH;
         S_SEARCH: if (w_p_hit || w_n_hit || w_last) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Status outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_SEARCH: busy = 1'b1;
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Search datapath and registered result. Plain form is tested before the
   // complement at each rotation so the smallest rotation, plain first, wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= 4'd0;
         r_val   <= 32'd0;
         r_found <= 1'b0;
         r_inv   <= 1'b0;
         r_rot   <= 4'd0;
         r_imm8  <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_val   <= value;
                  r_cnt   <= 4'd0;
                  r_found <= 1'b0;
                  r_inv   <= 1'b0;
                  r_rot   <= 4'd0;
                  r_imm8  <= 8'd0;
               end
            end
            S_SEARCH: begin
               if (w_p_hit) begin
                  r_found <= 1'b1;
                  r_inv   <= 1'b0;
                  r_rot   <= r_cnt;
                  r_imm8  <= w_p[7:0];
               end else if (w_n_hit) begin
                  r_found <= 1'b1;
                  r_inv   <= 1'b1;
                  r_rot   <= r_cnt;
                  r_imm8  <= w_n[7:0];
               end else if (w_last) begin
                  r_found <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign found    = r_found;
   assign inverted = r_inv;
   assign rot      = r_rot;
   assign imm8     = r_imm8;
   assign encoded  = {r_rot, r_imm8};

endmodule

// File: tb/tb_imm_rot_encoder.sv
module tb_imm_rot_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] value = 32'd0;
   logic        busy, done, found, inverted;
   logic [3:0]  rot;
   logic [7:0]  imm8;
   logic [11:0] encoded;

   int vectors = 0;
   int miscompares = 0;

   imm_rot_encoder dut (
      .clk(clk), .reset(reset), .start(start), .value(value),
      .busy(busy), .done(done), .found(found), .inverted(inverted),
      .rot(rot), .imm8(imm8), .encoded(encoded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [31:0] y;
      y = x;
      for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
      return y;
   endfunction

   // Reference: exhaustive search over every (rot, plain/complement, imm8)
   // in priority order, asking which 8-bit constant rotates onto the target.
   task automatic model(input logic [31:0] v, output logic f, output logic inv,
                        output logic [3:0] r, output logic [7:0] m);
      logic [31:0] t;
      f = 1'b0; inv = 1'b0; r = 4'd0; m = 8'd0;
      for (int rr = 0; rr < 16 && !f; rr++)
         for (int ii = 0; ii < 2 && !f; ii++) begin
            t = (ii == 1) ? ~v : v;
            for (int k = 0; k < 256 && !f; k++)
               if (ror(32'(k), 2 * rr) == t) begin
                  f = 1'b1; inv = (ii == 1); r = 4'(rr); m = 8'(k);
               end
         end
   endtask

   // One request: drive start, measure latency, check the result and the
   // done-pulse shape. inject=1 pulses a second start (0x12) mid-search.
   task automatic run(input logic [31:0] v, input bit inject);
      logic ef, ei;
      logic [3:0] er;
      logic [7:0] em;
      int k;
      int elat;
      model(v, ef, ei, er, em);
      elat = ef ? int'(er) + 2 : 17;
      @(negedge clk);
      start = 1'b1;
      value = v;
      @(posedge clk);
      #1 start = 1'b0;
      value = $urandom;
      k = 1;
      @(negedge clk);
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_clear", {found, inverted, encoded}, 32'd0);
      while (!done && k < 40) begin
         if (inject && k == 2) begin
            start = 1'b1;
            value = 32'h12;
         end
         @(posedge clk);
         #1 start = 1'b0;
         k++;
         @(negedge clk);
      end
      chk($sformatf("latency_%h", v), 32'(k), 32'(elat));
      chk($sformatf("found_%h", v), 32'(found), 32'(ef));
      chk($sformatf("inverted_%h", v), 32'(inverted), 32'(ei));
      chk($sformatf("encoded_%h", v), 32'(encoded), 32'({er, em}));
      chk("done_busy", 32'(busy), 32'd1);
      if (found)
         chk("invariant", ror(32'(imm8), 2 * int'(rot)), inverted ? ~v : v);
      @(negedge clk);
      chk("done_pulse", {done, busy}, 32'd0);
      chk("result_hold", 32'(encoded), 32'({er, em}));
   endtask

   initial begin
      logic [31:0] rv;
      repeat (3) @(negedge clk);
      chk("reset_state", {busy, done, found, inverted, encoded}, 32'd0);
      reset = 1'b0;

      run(32'h0000_00FF, 1'b0);
      run(32'hFF00_0000, 1'b0);
      run(32'h0000_0104, 1'b0);
      run(32'hFFFF_FF00, 1'b0);
      run(32'h0000_0000, 1'b0);
      run(32'h0000_0101, 1'b0);
      run(32'hFF00_0000, 1'b1);
      run(32'h0000_0012, 1'b0);

      // Reset during search of 0x104: no done pulse afterwards.
      @(negedge clk);
      start = 1'b1;
      value = 32'h0000_0104;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_outputs", {done, found, inverted, encoded}, 32'd0);
      begin
         int pulses = 0;
         repeat (20) begin
            @(negedge clk);
            if (done) pulses++;
         end
         chk("abort_no_done", 32'(pulses), 32'd0);
      end

      // Start and reset together: reset wins.
      @(negedge clk);
      start = 1'b1;
      reset = 1'b1;
      value = 32'hFF;
      @(posedge clk);
      #1 start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_beats_start", 32'(busy), 32'd0);

      // Randomized regression: mix of encodable, complement-encodable and raw.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: rv = ror(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
            1: rv = ~ror(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
            default: rv = $urandom;
         endcase
         run(rv, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
